// File: rtl/div_iter_pkg.sv
// Shared constants and helpers for the iterative 32-bit restoring divider.
// State codes match the core's DivFree/DivByZero/DivOn/DivEnd encoding.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic        DIV_RESULT_READY     = 1'b1;
  localparam logic        DIV_RESULT_NOT_READY = 1'b0;
  localparam logic [31:0] ZERO_WORD            = 32'h0000_0000;
  localparam logic [5:0]  DIV_CNT_LAST         = 6'd32;

  // Magnitude of an operand; only negative values in signed mode are complemented.
  function automatic logic [31:0] div_mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider, one quotient bit per clock, serving DIV/DIVU.
// Produces {remainder, quotient} 34 edges after a start is accepted.
module div_iter
  import div_iter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  r_state, w_state;
  logic [64:0] r_dividend, w_dividend;
  logic [31:0] r_divisor, w_divisor;
  logic [5:0]  r_cnt, w_cnt;
  logic        r_neg1, w_neg1;
  logic        r_neg2, w_neg2;
  logic [63:0] r_result, w_result;
  logic        r_ready, w_ready;

  logic [32:0] w_diff;
  logic [31:0] w_quot, w_rem;

  // Trial subtract of the partial remainder window; bit 32 set means it went negative.
  assign w_diff = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};
  assign w_quot = (r_neg1 ^ r_neg2) ? (32'd0 - r_dividend[31:0])  : r_dividend[31:0];
  assign w_rem  = r_neg1            ? (32'd0 - r_dividend[64:33]) : r_dividend[64:33];

  always_comb begin
    w_state    = r_state;
    w_dividend = r_dividend;
    w_divisor  = r_divisor;
    w_cnt      = r_cnt;
    w_neg1     = r_neg1;
    w_neg2     = r_neg2;
    w_result   = r_result;
    w_ready    = r_ready;
    case (r_state)
      DIV_FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == ZERO_WORD) begin
            w_state = DIV_BY_ZERO;
          end else begin
            w_state    = DIV_ON;
            w_cnt      = 6'd0;
            w_neg1     = signed_div_i & opdata1_i[31];
            w_neg2     = signed_div_i & opdata2_i[31];
            w_divisor  = div_mag(opdata2_i, signed_div_i);
            w_dividend = {32'd0, div_mag(opdata1_i, signed_div_i), 1'b0};
          end
        end
      end
      DIV_BY_ZERO: begin
        w_dividend = 65'd0;
        w_state    = DIV_END;
      end
      DIV_ON: begin
        if (annul_i) begin
          w_state = DIV_FREE;
          w_cnt   = 6'd0;
        end else if (r_cnt != DIV_CNT_LAST) begin
          if (w_diff[32]) w_dividend = {r_dividend[63:0], 1'b0};
          else            w_dividend = {w_diff[31:0], r_dividend[31:0], 1'b1};
          w_cnt = r_cnt + 6'd1;
        end else begin
          // Corrected values are parked in the same bit positions END reads from.
          w_dividend = {w_rem, 1'b0, w_quot};
          w_state    = DIV_END;
          w_cnt      = 6'd0;
        end
      end
      DIV_END: begin
        if (start_i) begin
          w_result = {r_dividend[64:33], r_dividend[31:0]};
          w_ready  = DIV_RESULT_READY;
        end else begin
          w_state  = DIV_FREE;
          w_result = 64'd0;
          w_ready  = DIV_RESULT_NOT_READY;
        end
      end
      default: w_state = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= DIV_FREE;
      r_dividend <= 65'd0;
      r_divisor  <= 32'd0;
      r_cnt      <= 6'd0;
      r_neg1     <= 1'b0;
      r_neg2     <= 1'b0;
      r_result   <= 64'd0;
      r_ready    <= DIV_RESULT_NOT_READY;
    end else begin
      r_state    <= w_state;
      r_dividend <= w_dividend;
      r_divisor  <= w_divisor;
      r_cnt      <= w_cnt;
      r_neg1     <= w_neg1;
      r_neg2     <= w_neg2;
      r_result   <= w_result;
      r_ready    <= w_ready;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_iter.sv
// Randomised bench for div_iter: an arithmetic reference plus an edge-count timing
// model is compared against ready_o/result_o on every cycle.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam int NEVER = 32'h3fff_ffff;
  // Model: op accepted at edge m_n, result visible from edge m_n+m_lat until edge m_drop.
  int          m_n    = NEVER;
  int          m_lat  = 34;
  int          m_drop = NEVER;
  logic [63:0] m_res  = 64'd0;

  div_iter dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  initial begin
    forever begin
      logic er;
      @(negedge clk);
      #1;
      er = (cyc >= m_n + m_lat) && (cyc < m_drop);
      check("ready", {63'd0, ready_o}, {63'd0, er});
      check("result", result_o, er ? m_res : 64'd0);
    end
  end

  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    m_res        = ref_div(sgn, a, b);
    m_lat        = (b == 32'd0) ? 2 : 34;
    m_drop       = NEVER;
    m_n          = cyc + 1;
  endtask

  task automatic finish_op(input logic use_lit, input logic [63:0] lit, input bit wiggle);
    int k;
    if (use_lit) check("model", m_res, lit);
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ready_o) break;
      if (wiggle && m_lat == 34 && cyc < m_n + 30) start_i = 1'($urandom_range(0, 1));
      else start_i = 1'b1;
    end
    if (k == 60) begin
      checks++;
      errors++;
      $display("FAIL timeout: ready_o not seen after 60 cycles, expected after %0d", m_lat);
    end else begin
      check("latency", 64'(cyc - m_n), 64'(m_lat));
      if (use_lit) check("result_lit", result_o, lit);
    end
    start_i = 1'b0;
    m_drop  = cyc + 1;
    @(negedge clk);
  endtask

  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic use_lit, input logic [63:0] lit, input bit wiggle);
    launch(sgn, a, b);
    finish_op(use_lit, lit, wiggle);
  endtask

  initial begin
    logic [31:0] a, b;
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(1'b0, 32'd100, 32'd7, 1'b1, 64'h00000002_0000000E, 1'b0);
    do_op(1'b1, 32'hFFFFFF9C, 32'd7, 1'b1, 64'hFFFFFFFE_FFFFFFF2, 1'b0);
    do_op(1'b0, 32'hFFFFFF9C, 32'd7, 1'b1, 64'h00000002_24924916, 1'b0);
    do_op(1'b0, 32'd5, 32'd0, 1'b1, 64'd0, 1'b0);
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 1'b0);

    // Annul mid-operation, then restart on the very next cycle.
    launch(1'b0, 32'd100, 32'd7);
    while (cyc < m_n + 9) @(negedge clk);
    annul_i = 1'b1;
    m_n     = NEVER;
    @(negedge clk);
    launch(1'b1, 32'd100, 32'hFFFFFFF9);
    finish_op(1'b1, 64'h00000002_FFFFFFF2, 1'b0);

    // Start paired with annul in FREE is not accepted.
    signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd2;
    start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    do_op(1'b0, 32'd9, 32'd2, 1'b1, 64'h00000001_00000004, 1'b0);

    // Synchronous reset in the middle of a divide.
    launch(1'b0, 32'hDEADBEEF, 32'd3);
    while (cyc < m_n + 19) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    m_n     = NEVER;
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 1'b0);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      do_op(1'($urandom_range(0, 1)), a, b, 1'b0, 64'd0, 1'b1);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
